// File: rtl/stoch_op_scheduler_pkg.sv
// Shared types and constants for the stochastic-arithmetic job scheduler.
package stoch_sched_pkg;

  localparam int RES_W        = 9;
  localparam int WIN_LOG2_MIN = 9;
  localparam int WIN_LOG2_MAX = 20;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SMUL = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/stoch_op_scheduler_if.sv
// Job request / result handshake bundle between a requester (master) and the scheduler (slave).
interface stoch_op_scheduler_if;
  import stoch_sched_pkg::*;

  logic             job_valid;
  logic             job_ready;
  logic [1:0]       job_op;
  logic [RES_W-1:0] job_a;
  logic [RES_W-1:0] job_b;

  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_value;
  logic [1:0]       res_op;
  logic             res_err;

  modport master (
    output job_valid, job_op, job_a, job_b, res_ready,
    input  job_ready, res_valid, res_value, res_op, res_err
  );

  modport slave (
    input  job_valid, job_op, job_a, job_b, res_ready,
    output job_ready, res_valid, res_value, res_op, res_err
  );

endinterface

// File: rtl/stoch_op_scheduler_accum.sv
// Window/ones counters for one bitstream window, plus saturate-and-shift to a 9-bit probability.
module stoch_window_accum
  import stoch_sched_pkg::*;
#(
  parameter int WIN_LOG2 = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             sn_bit_i,
  output logic             done_o,
  output logic [RES_W-1:0] result_o
);

  localparam logic [WIN_LOG2:0] LAST_CNT = {1'b0, {WIN_LOG2{1'b1}}};
  localparam logic [WIN_LOG2:0] ONE_CNT  = {{WIN_LOG2{1'b0}}, 1'b1};

  logic [WIN_LOG2:0] win_cnt_q, win_cnt_d;
  logic [WIN_LOG2:0] one_cnt_q, one_cnt_d;

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    win_cnt_d = win_cnt_q;
    one_cnt_d = one_cnt_q;
    if (clr_i) begin
      win_cnt_d = '0;
      one_cnt_d = '0;
    end else if (en_i) begin
      win_cnt_d = win_cnt_q + ONE_CNT;
      one_cnt_d = one_cnt_q + {{WIN_LOG2{1'b0}}, sn_bit_i};
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      win_cnt_q <= '0;
      one_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      one_cnt_q <= one_cnt_d;
    end
  end

  assign done_o = en_i && (win_cnt_q == LAST_CNT);

  // An all-ones window counts 2^WIN_LOG2, which would wrap the top bits; clamp it to full scale.
  assign result_o = one_cnt_d[WIN_LOG2] ? '1 : one_cnt_d[WIN_LOG2-1 -: RES_W];

endmodule

// File: rtl/stoch_op_scheduler.sv
// Job sequencer for the stochastic datapath: accept op, reload LFSR, count one window, return result.
// Define STOCH_SCHED_WARMUP_EN to add one discard cycle at the start of RUN.
module stoch_op_scheduler
  import stoch_sched_pkg::*;
#(
  parameter int WIN_LOG2 = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stoch_op_scheduler_if.slave  bus,
  output logic [RES_W-1:0]     op_a_o,
  output logic [RES_W-1:0]     op_b_o,
  output logic [1:0]           op_sel_o,
  output logic                 lfsr_load_o,
  output logic                 sn_en_o,
  input  logic                 sn_bit_i,
  output logic                 busy
);

  state_e           state_q, state_d;
  logic             job_ready_q, res_valid_q, res_err_q;
  logic             lfsr_load_q, sn_en_q, busy_q;
  logic [RES_W-1:0] op_a_q, op_b_q, res_value_q;
  logic [1:0]       op_sel_q, res_op_q;

  logic             accept, is_rsvd;
  logic             acc_clr, acc_en, acc_done, sn_en_d;
  logic [RES_W-1:0] acc_result;

  assign accept  = bus.job_valid && job_ready_q;
  assign is_rsvd = (bus.job_op == OP_RSVD);
  assign acc_clr = (state_q == ST_LOAD);

`ifdef STOCH_SCHED_WARMUP_EN
  logic warm_q;

  // First RUN cycle only flushes the self-multiplier delay flop after the reload.
  always_ff @(posedge clk) begin
    if (rst_n) warm_q <= 1'b0;
    else       warm_q <= (state_q == ST_LOAD);
  end

  assign acc_en  = (state_q == ST_RUN) && !warm_q;
  assign sn_en_d = (state_d == ST_RUN) && (state_q != ST_LOAD);
`else
  assign acc_en  = (state_q == ST_RUN);
  assign sn_en_d = (state_d == ST_RUN);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_rsvd ? ST_DONE : ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (acc_done) state_d = ST_DONE;
      ST_DONE: if (res_valid_q && bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      job_ready_q <= 1'b1;
      lfsr_load_q <= 1'b0;
      sn_en_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      res_value_q <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_ready_q <= (state_d == ST_IDLE);
      lfsr_load_q <= (state_d == ST_LOAD);
      sn_en_q     <= sn_en_d;
      res_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
      if (accept) begin
        op_a_q   <= bus.job_a;
        op_b_q   <= bus.job_b;
        op_sel_q <= bus.job_op;
      end
      // Result fields load only on entry to DONE, so they hold steady while stalled.
      if (accept && is_rsvd) begin
        res_value_q <= '0;
        res_op_q    <= bus.job_op;
        res_err_q   <= 1'b1;
      end else if ((state_q == ST_RUN) && acc_done) begin
        res_value_q <= acc_result;
        res_op_q    <= op_sel_q;
        res_err_q   <= 1'b0;
      end
    end
  end

  stoch_window_accum #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .sn_bit_i (sn_bit_i),
    .done_o   (acc_done),
    .result_o (acc_result)
  );

  assign bus.job_ready = job_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_value = res_value_q;
  assign bus.res_op    = res_op_q;
  assign bus.res_err   = res_err_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
  assign op_sel_o      = op_sel_q;
  assign lfsr_load_o   = lfsr_load_q;
  assign sn_en_o       = sn_en_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_stoch_op_scheduler.sv
// Directed, table-driven bench for stoch_op_scheduler with a 512-cycle window.
module tb_stoch_op_scheduler;
  import stoch_sched_pkg::*;

  localparam int WL      = 9;
  localparam int WIN     = 1 << WL;
  localparam int LAT_EDG = WIN + 1;  // edges after the accept edge until res_valid is seen

  typedef enum int {PAT_ONES, PAT_ZEROS, PAT_ALT} pat_e;

  typedef struct {
    logic [1:0] op;
    logic [8:0] a;
    logic [8:0] b;
    pat_e       pat;
    bit         stall;
    logic [8:0] exp_val;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sn_bit_i;
  logic [8:0] op_a_o, op_b_o;
  logic [1:0] op_sel_o;
  logic       lfsr_load_o, sn_en_o, busy;

  int checks   = 0;
  int failures = 0;

  stoch_op_scheduler_if bus ();

  stoch_op_scheduler #(.WIN_LOG2(WL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .op_a_o      (op_a_o),
    .op_b_o      (op_b_o),
    .op_sel_o    (op_sel_o),
    .lfsr_load_o (lfsr_load_o),
    .sn_en_o     (sn_en_o),
    .sn_bit_i    (sn_bit_i),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat_bit(input pat_e p, input int idx);
    case (p)
      PAT_ONES: return 1'b1;
      PAT_ALT:  return (idx % 2 == 0);
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 50 && bus.job_ready !== 1'b1; i++) tick();
    check("job_ready_before_accept", bus.job_ready, 1);
  endtask

  task automatic run_job(input vec_t v, input int id);
    int lat, en_cnt, ld_cnt;
    lat = -1; en_cnt = 0; ld_cnt = 0;
    bus.res_ready = !v.stall;
    wait_ready();
    bus.job_valid = 1'b1;
    bus.job_op    = v.op;
    bus.job_a     = v.a;
    bus.job_b     = v.b;
    tick();
    bus.job_valid = 1'b0;
    check($sformatf("v%0d op_a_o", id), op_a_o, v.a);
    check($sformatf("v%0d op_b_o", id), op_b_o, v.b);
    check($sformatf("v%0d op_sel_o", id), op_sel_o, v.op);
    check($sformatf("v%0d lfsr_load_T1", id), lfsr_load_o, (v.op != 2'b11));
    check($sformatf("v%0d job_ready_busy", id), bus.job_ready, 0);
    if (v.op == 2'b11) begin
      check($sformatf("v%0d rsvd_res_valid_T1", id), bus.res_valid, 1);
      check($sformatf("v%0d rsvd_sn_en", id), sn_en_o, 0);
    end else begin
      for (int cyc = 1; cyc <= 600 && lat < 0; cyc++) begin
        tick();
        if (lfsr_load_o) ld_cnt++;
        if (sn_en_o) begin
          sn_bit_i = pat_bit(v.pat, en_cnt);
          en_cnt++;
        end else begin
          sn_bit_i = 1'b0;
        end
        if (bus.res_valid) lat = cyc;
      end
      check($sformatf("v%0d latency", id), lat, LAT_EDG);
      check($sformatf("v%0d sn_en_cycles", id), en_cnt, WIN);
      check($sformatf("v%0d extra_lfsr_load", id), ld_cnt, 0);
    end
    check($sformatf("v%0d res_value", id), bus.res_value, v.exp_val);
    check($sformatf("v%0d res_op", id), bus.res_op, v.op);
    check($sformatf("v%0d res_err", id), bus.res_err, v.exp_err);
    check($sformatf("v%0d busy", id), busy, 1);
    if (v.stall) begin
      for (int i = 0; i < 20; i++) begin
        bus.job_valid = (i % 3 == 0);
        tick();
        check($sformatf("v%0d stall_res_valid", id), bus.res_valid, 1);
        check($sformatf("v%0d stall_res_value", id), bus.res_value, v.exp_val);
        check($sformatf("v%0d stall_res_op", id), bus.res_op, v.op);
        check($sformatf("v%0d stall_job_ready", id), bus.job_ready, 0);
      end
      bus.job_valid = 1'b0;
      bus.res_ready = 1'b1;
    end
    tick();
    check($sformatf("v%0d post_res_valid", id), bus.res_valid, 0);
    check($sformatf("v%0d post_job_ready", id), bus.job_ready, 1);
    check($sformatf("v%0d post_busy", id), busy, 0);
    check($sformatf("v%0d op_a_hold", id), op_a_o, v.a);
    tick();
    check($sformatf("v%0d idle_no_load", id), lfsr_load_o, 0);
    check($sformatf("v%0d idle_busy", id), busy, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int en_cnt, seen;
    vecs[0] = '{op: 2'b00, a: 9'h0AB, b: 9'h155, pat: PAT_ONES,  stall: 1'b0, exp_val: 9'h1FF, exp_err: 1'b0};
    vecs[1] = '{op: 2'b01, a: 9'h1FF, b: 9'h000, pat: PAT_ZEROS, stall: 1'b0, exp_val: 9'h000, exp_err: 1'b0};
    vecs[2] = '{op: 2'b10, a: 9'h100, b: 9'h007, pat: PAT_ALT,   stall: 1'b0, exp_val: 9'h100, exp_err: 1'b0};
    vecs[3] = '{op: 2'b11, a: 9'h012, b: 9'h034, pat: PAT_ONES,  stall: 1'b0, exp_val: 9'h000, exp_err: 1'b1};
    vecs[4] = '{op: 2'b00, a: 9'h123, b: 9'h0F0, pat: PAT_ALT,   stall: 1'b1, exp_val: 9'h100, exp_err: 1'b0};
    vecs[5] = '{op: 2'b01, a: 9'h055, b: 9'h1AA, pat: PAT_ONES,  stall: 1'b0, exp_val: 9'h1FF, exp_err: 1'b0};

    rst_n         = 1'b1;
    sn_bit_i      = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_op    = 2'b00;
    bus.job_a     = '0;
    bus.job_b     = '0;
    bus.res_ready = 1'b1;
    tick();
    tick();
    check("rst_job_ready", bus.job_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_value", bus.res_value, 0);
    check("rst_res_op", bus.res_op, 0);
    check("rst_res_err", bus.res_err, 0);
    check("rst_op_a", op_a_o, 0);
    check("rst_op_b", op_b_o, 0);
    check("rst_op_sel", op_sel_o, 0);
    check("rst_lfsr_load", lfsr_load_o, 0);
    check("rst_sn_en", sn_en_o, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // Reset in the middle of RUN abandons the job without a result.
    wait_ready();
    bus.job_valid = 1'b1;
    bus.job_op    = 2'b00;
    bus.job_a     = 9'h0C3;
    bus.job_b     = 9'h03C;
    tick();
    bus.job_valid = 1'b0;
    en_cnt = 0;
    for (int cyc = 0; cyc < 200 && en_cnt < 100; cyc++) begin
      tick();
      if (sn_en_o) en_cnt++;
      sn_bit_i = 1'b1;
    end
    check("midrst_reached_run100", en_cnt, 100);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_sn_en", sn_en_o, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_job_ready", bus.job_ready, 1);
    seen = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      if (bus.res_valid || sn_en_o || lfsr_load_o) seen++;
    end
    check("midrst_no_result", seen, 0);
    sn_bit_i = 1'b0;

    run_job(vecs[0], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
